demux_stream_1xn: RTL and testbench

DEMUX_STREAM_1XN -- requirements
Module: demux_stream_1xn

---
 rtl/demux_stream_1xn.sv | 154 +++++++++++++++
 tb/tb_demux_stream_1xn.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: routes valid/ready packets from one input stream to one of N
// output channels. The destination is chosen on the first beat of each packet.
// Packets with an out-of-range destination are accepted, discarded and counted.
module demux_stream_1xn #(
    parameter int unsigned DW   = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              in_last,
    input  logic [SELW-1:0]   in_sel,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic [N*DW-1:0]   out_data,
    output logic [N-1:0]      out_last,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SELW-1:0] ch_q;
    logic [SELW-1:0] ch_d;
    logic [7:0]      drop_d;
    logic            sel_ok;
    logic            routing;
    logic            tgt_open;
    logic            accept;
    logic [SELW-1:0] tgt;
    logic [N-1:0]    load;

    // Target channel and whether its output register can take a beat this cycle
    always_comb begin
        sel_ok   = (32'(in_sel) < N);
        tgt      = (state_q == S_ROUTE) ? ch_q : in_sel;
        tgt_open = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (tgt == SELW'(k)) begin
                tgt_open = ~out_valid[k] | out_ready[k];
            end
        end
    end

    // Input readiness: routed beats wait on the target channel, discarded beats never wait
    always_comb begin
        in_ready = 1'b0;
        routing  = 1'b0;
        case (state_q)
            S_IDLE: begin
                routing  = sel_ok;
                in_ready = sel_ok ? tgt_open : 1'b1;
            end
            S_ROUTE: begin
                routing  = 1'b1;
                in_ready = tgt_open;
            end
            S_DROP: begin
                in_ready = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept = in_valid & in_ready;

    // Per-channel load strobes for an accepted routed beat
    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < N; k++) begin
            load[k] = accept & routing & (tgt == SELW'(k));
        end
    end

    // Next-state logic: packet lock, discard mode and drop counting
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        drop_d  = drop_cnt;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        ch_d = in_sel;
                        if (!in_last) begin
                            state_d = S_ROUTE;
                        end
                    end else begin
                        if (drop_cnt != 8'hFF) begin
                            drop_d = drop_cnt + 8'd1;
                        end
                        if (!in_last) begin
                            state_d = S_DROP;
                        end
                    end
                end
            end
            S_ROUTE, S_DROP: begin
                if (accept && in_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, locked channel and drop counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            drop_cnt <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            drop_cnt <= drop_d;
        end
    end

    // One-deep output register per channel: load wins over drain, payload held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (load[k]) begin
                    out_valid[k]          <= 1'b1;
                    out_data[k*DW +: DW]  <= in_data;
                    out_last[k]           <= in_last;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn: scenario tasks against a packet-level scoreboard model
// (per-channel pending-beat queues); a second N=5 instance exercises discards.
module tb_demux_stream_1xn;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;
    localparam int N5    = 5;
    localparam int SELW5 = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              in_last;
    logic [SELW-1:0]   in_sel;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_last;
    logic [7:0]        drop_cnt;

    logic              r5;
    logic              v5;
    logic              rdy5;
    logic [DW-1:0]     d5;
    logic              l5;
    logic [SELW5-1:0]  s5;
    logic [N5-1:0]     ov5;
    logic [N5-1:0]     or5;
    logic [N5*DW-1:0]  od5;
    logic [N5-1:0]     ol5;
    logic [7:0]        dc5;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: beats accepted for a channel but not yet drained
    logic [DW-1:0] q_data [N][$];
    logic          q_last [N][$];
    bit            m_busy;
    int            m_dest;

    always #5 clk = ~clk;

    demux_stream_1xn #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .drop_cnt(drop_cnt)
    );

    demux_stream_1xn #(.DW(DW), .N(N5), .SELW(SELW5)) dut5 (
        .clk(clk), .rst(r5), .in_valid(v5), .in_ready(rdy5),
        .in_data(d5), .in_last(l5), .in_sel(s5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5),
        .out_last(ol5), .drop_cnt(dc5)
    );

    // Expected outputs from the scoreboard and the current inputs
    function automatic void model_exp(output logic [N-1:0] ev, output logic [N*DW-1:0] ed,
                                      output logic [N-1:0] el, output logic [N*DW-1:0] msk,
                                      output logic er);
        int dest;
        int sel_i;
        ev  = '0;
        ed  = '0;
        el  = '0;
        msk = '0;
        for (int k = 0; k < N; k++) begin
            if (q_data[k].size() > 0) begin
                ev[k]            = 1'b1;
                ed[k*DW +: DW]   = q_data[k][0];
                el[k]            = q_last[k][0];
                msk[k*DW +: DW]  = '1;
            end
        end
        sel_i = int'(in_sel);
        dest  = m_busy ? m_dest : ((sel_i < N) ? sel_i : -1);
        if (rst)           er = 1'b0;
        else if (dest < 0) er = 1'b1;
        else               er = (q_data[dest].size() == 0) || out_ready[dest];
    endfunction

    // Advance the scoreboard by one clock edge using the inputs presented this cycle
    function automatic void model_clock();
        logic [N-1:0]    ev;
        logic [N-1:0]    el;
        logic [N*DW-1:0] ed;
        logic [N*DW-1:0] msk;
        logic            er;
        int              dest;
        int              sel_i;
        model_exp(ev, ed, el, msk, er);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                q_data[k].delete();
                q_last[k].delete();
            end
            m_busy = 1'b0;
            m_dest = 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            if (q_data[k].size() > 0 && out_ready[k]) begin
                void'(q_data[k].pop_front());
                void'(q_last[k].pop_front());
            end
        end
        if (in_valid && er) begin
            sel_i = int'(in_sel);
            if (!m_busy) begin
                dest = (sel_i < N) ? sel_i : -1;
                if (!in_last) begin
                    m_busy = 1'b1;
                    m_dest = dest;
                end
            end else begin
                dest = m_dest;
                if (in_last) m_busy = 1'b0;
            end
            if (dest >= 0) begin
                q_data[dest].push_back(in_data);
                q_last[dest].push_back(in_last);
            end
        end
    endfunction

    task automatic test_reset();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        for (int i = 0; i < 3; i++) begin
            rst = (i < 2); in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h5A; in_last = 1'b0;
            out_ready = '0;
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            if (i < 2) begin
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready cyc%0d got %b want 0", i, in_ready); end
            end else begin
                n_tests++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
                n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data got %h want 0", out_data); end
                n_tests++; if (out_last !== '0) begin n_fail++; $display("FAIL reset out_last got %b want 0", out_last); end
                n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset drop_cnt got %0d want 0", drop_cnt); end
            end
            model_clock();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_packet();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        int hi_cnt = 0;
        rst = 1'b0; out_ready = '1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3); in_sel = 2'd2; in_last = (i == 2);
            in_data  = (i < 3) ? DW'(8'h11 * (i + 1)) : 8'h00;
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL single in_ready cyc%0d got %b want %b", i, in_ready, er); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL single out_valid cyc%0d got %b want %b", i, out_valid, ev); end
            n_tests++; if ((out_data & msk) !== ed) begin n_fail++; $display("FAIL single out_data cyc%0d got %h want %h", i, out_data & msk, ed); end
            n_tests++; if ((out_last & ev) !== el) begin n_fail++; $display("FAIL single out_last cyc%0d got %b want %b", i, out_last & ev, el); end
            if (out_valid === 4'b0100) hi_cnt++;
            model_clock();
            @(posedge clk); #1;
        end
        n_tests++; if (hi_cnt != 3) begin n_fail++; $display("FAIL single ch2_cycles got %0d want 3", hi_cnt); end
    endtask

    task automatic test_sel_ignored();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        int c1 = 0; int c3 = 0;
        rst = 1'b0; out_ready = '1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i < 2); in_sel = (i == 0) ? 2'd1 : 2'd3; in_last = (i == 1);
            in_data  = (i == 0) ? 8'hA1 : 8'hA2;
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL selign in_ready cyc%0d got %b want %b", i, in_ready, er); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL selign out_valid cyc%0d got %b want %b", i, out_valid, ev); end
            n_tests++; if ((out_data & msk) !== ed) begin n_fail++; $display("FAIL selign out_data cyc%0d got %h want %h", i, out_data & msk, ed); end
            if (out_valid[1] === 1'b1) c1++;
            if (out_valid[3] === 1'b1) c3++;
            model_clock();
            @(posedge clk); #1;
        end
        n_tests++; if (c1 != 2 || c3 != 0) begin n_fail++; $display("FAIL selign counts got ch1=%0d ch3=%0d want ch1=2 ch3=0", c1, c3); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b0; in_sel = 2'd0; in_last = 1'b0; in_data = 8'h00; out_ready = 4'b1110;
            case (i)
                0:       begin in_valid = 1'b1; in_data = 8'h11; end
                1, 2, 3: begin in_valid = 1'b1; in_data = 8'h22; in_last = 1'b1; end
                4:       begin in_valid = 1'b1; in_data = 8'h22; in_last = 1'b1; out_ready = 4'b1111; end
                6:       begin in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h44; end
                7:       begin in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; in_last = 1'b1; end
                10:      out_ready = 4'b1111;
                default: ;
            endcase
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL bp in_ready cyc%0d got %b want %b", i, in_ready, er); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL bp out_valid cyc%0d got %b want %b", i, out_valid, ev); end
            n_tests++; if ((out_data & msk) !== ed) begin n_fail++; $display("FAIL bp out_data cyc%0d got %h want %h", i, out_data & msk, ed); end
            n_tests++; if ((out_last & ev) !== el) begin n_fail++; $display("FAIL bp out_last cyc%0d got %b want %b", i, out_last & ev, el); end
            if (i == 3) begin
                n_tests++; if (out_data[7:0] !== 8'h11 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp held got data %h ready %b want 11 0", out_data[7:0], in_ready); end
            end
            if (i == 5) begin
                n_tests++; if (out_data[7:0] !== 8'h22 || out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp second got data %h valid %b want 22 1", out_data[7:0], out_valid[0]); end
            end
            if (i == 7) begin
                n_tests++; if (out_valid !== 4'b1001 || out_data[31:24] !== 8'h44) begin n_fail++; $display("FAIL bp ch3 got valid %b data %h want 1001 44", out_valid, out_data[31:24]); end
            end
            model_clock();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        out_ready = '1;
        for (int i = 0; i < 4; i++) begin
            rst = (i == 1); in_valid = (i < 3); in_last = (i == 2);
            in_sel  = (i == 2) ? 2'd0 : 2'd2;
            in_data = (i == 2) ? 8'h77 : 8'h11;
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL rstmid in_ready cyc%0d got %b want %b", i, in_ready, er); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rstmid out_valid cyc%0d got %b want %b", i, out_valid, ev); end
            n_tests++; if ((out_data & msk) !== ed) begin n_fail++; $display("FAIL rstmid out_data cyc%0d got %h want %h", i, out_data & msk, ed); end
            if (i == 2) begin
                n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rstmid cleared got %b want 0000", out_valid); end
            end
            if (i == 3) begin
                n_tests++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h77) begin n_fail++; $display("FAIL rstmid ch0 got valid %b data %h want 0001 77", out_valid, out_data[7:0]); end
            end
            model_clock();
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        logic [SELW-1:0] sels [5];
        logic [DW-1:0]   dats [5];
        sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd2; sels[3] = 2'd3; sels[4] = 2'd0;
        for (int j = 0; j < 5; j++) dats[j] = DW'($urandom);
        rst = 1'b0; out_ready = '1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 5); in_last = 1'b1;
            in_sel   = (i < 5) ? sels[i] : 2'd0;
            in_data  = (i < 5) ? dats[i] : 8'h00;
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL b2b in_ready cyc%0d got %b want %b", i, in_ready, er); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL b2b out_valid cyc%0d got %b want %b", i, out_valid, ev); end
            n_tests++; if ((out_data & msk) !== ed) begin n_fail++; $display("FAIL b2b out_data cyc%0d got %h want %h", i, out_data & msk, ed); end
            if (i < 5) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b nobubble cyc%0d got %b want 1", i, in_ready); end
            end
            if (i > 0) begin
                n_tests++;
                if (out_valid !== (4'b0001 << sels[i-1]) || out_last[sels[i-1]] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b route cyc%0d got valid %b last %b want sel %0d", i, out_valid, out_last, sels[i-1]);
                end
            end
            model_clock();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ev, el; logic [N*DW-1:0] ed, msk; logic er;
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SELW'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            in_data   = DW'($urandom);
            out_ready = N'($urandom) | N'($urandom);
            @(negedge clk);
            model_exp(ev, ed, el, msk, er);
            n_tests++; if (in_ready !== er) begin n_fail++; $display("FAIL rand in_ready cyc%0d got %b want %b", i, in_ready, er); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rand out_valid cyc%0d got %b want %b", i, out_valid, ev); end
            n_tests++; if ((out_data & msk) !== ed) begin n_fail++; $display("FAIL rand out_data cyc%0d got %h want %h", i, out_data & msk, ed); end
            n_tests++; if ((out_last & ev) !== el) begin n_fail++; $display("FAIL rand out_last cyc%0d got %b want %b", i, out_last & ev, el); end
            n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rand drop_cnt cyc%0d got %0d want 0", i, drop_cnt); end
            model_clock();
            @(posedge clk); #1;
        end
    endtask

    // Discard path on the N=5 / SELW=3 instance; main instance idles alongside
    task automatic test_drop();
        int exp_drop = 0;
        in_valid = 1'b0; out_ready = '1; rst = 1'b0;
        or5 = '1; v5 = 1'b0; d5 = 8'h00; l5 = 1'b0; s5 = 3'd0; r5 = 1'b1;
        @(negedge clk); model_clock(); @(posedge clk); #1;
        r5 = 1'b0;
        for (int p = 0; p < 257; p++) begin
            for (int b = 0; b < 2; b++) begin
                v5 = 1'b1; l5 = (b == 1); d5 = DW'($urandom);
                s5 = (p == 0) ? 3'd7 : ((b == 0) ? SELW5'($urandom_range(5, 7)) : SELW5'($urandom));
                @(negedge clk);
                n_tests++; if (rdy5 !== 1'b1) begin n_fail++; $display("FAIL drop in_ready pkt%0d beat%0d got %b want 1", p, b, rdy5); end
                n_tests++; if (ov5 !== '0) begin n_fail++; $display("FAIL drop out_valid pkt%0d beat%0d got %b want 0", p, b, ov5); end
                n_tests++; if (dc5 !== 8'(exp_drop)) begin n_fail++; $display("FAIL drop drop_cnt pkt%0d beat%0d got %0d want %0d", p, b, dc5, exp_drop); end
                if (b == 0 && exp_drop < 255) exp_drop++;
                model_clock();
                @(posedge clk); #1;
            end
        end
        v5 = 1'b1; l5 = 1'b1; s5 = 3'd4; d5 = 8'hC4;
        @(negedge clk);
        n_tests++; if (rdy5 !== 1'b1) begin n_fail++; $display("FAIL drop valid_sel in_ready got %b want 1", rdy5); end
        model_clock(); @(posedge clk); #1;
        v5 = 1'b0; or5 = '0;
        @(negedge clk);
        n_tests++; if (ov5 !== 5'b10000 || od5[39:32] !== 8'hC4 || ol5[4] !== 1'b1) begin n_fail++; $display("FAIL drop ch4 got valid %b data %h last %b want 10000 c4 1", ov5, od5[39:32], ol5[4]); end
        n_tests++; if (dc5 !== 8'd255) begin n_fail++; $display("FAIL drop saturate got %0d want 255", dc5); end
        model_clock(); @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = '0; out_ready = '0;
        r5 = 1'b1; v5 = 1'b0; d5 = '0; l5 = 1'b0; s5 = '0; or5 = '0;
        m_busy = 1'b0; m_dest = 0;
        #1;
        test_reset();
        test_single_packet();
        test_sel_ignored();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
